// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep sequencer: FSM states, MODE_SEL
// encodings, first/last vector per mode, and the golden gate function.
// Imported by the controller, the golden model and the bench.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] MODE_M0   = 2'b00;  // NAND vectors only
  localparam logic [1:0] MODE_M1   = 2'b01;  // inverted-majority vectors only
  localparam logic [1:0] MODE_BOTH = 2'b10;  // all 16 vectors
  localparam logic [1:0] MODE_RSVD = 2'b11;  // behaves like MODE_BOTH

  localparam logic [3:0] VEC_FIRST_M0  = 4'b0000;
  localparam logic [3:0] VEC_FIRST_M1  = 4'b1000;
  localparam logic [3:0] VEC_LAST_M0   = 4'b0111;
  localparam logic [3:0] VEC_LAST_FULL = 4'b1111;

  // First {M,A,B,C} of a sweep for the latched mode.
  function automatic logic [3:0] first_vec(input logic [1:0] mode);
    return (mode == MODE_M1) ? VEC_FIRST_M1 : VEC_FIRST_M0;
  endfunction

  // Last {M,A,B,C} of a sweep for the latched mode.
  function automatic logic [3:0] last_vec(input logic [1:0] mode);
    return (mode == MODE_M0) ? VEC_LAST_M0 : VEC_LAST_FULL;
  endfunction

  // Expected gate output for vector {M,A,B,C}.
  function automatic logic golden(input logic [3:0] v);
    logic m, a, b, c;
    {m, a, b, c} = v;
    return m ? ~((a & b) | (a & c) | (b & c)) : ~(a & b & c);
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational golden reference for the mode-selectable 3-input gate.
// Ports: vec_i = {M,A,B,C} stimulus, exp_o = expected gate output.
// Zero latency, no flow control.
module gate_golden_model
  import gate_sweep_pkg::*;
(
  input  logic [3:0] vec_i,
  output logic       exp_o
);

  assign exp_o = golden(vec_i);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps M/A/B/C over the selected vector set, holds each for SETTLE_CYC
// cycles, samples Y and checks it against the golden model.
// Ports: CLK/RST_N, START/ABORT/MODE_SEL control, Y from the gate unit;
// M/A/B/C stimulus, BUSY/DONE status, FAIL/ERR_CNT/FIRST_FAIL results.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2  // legal 1..15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       ABORT,
  input  logic [1:0] MODE_SEL,
  input  logic       Y,
  output logic       M,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [4:0] ERR_CNT,
  output logic [3:0] FIRST_FAIL
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  state_e     state_q;
  logic [1:0] mode_q;
  logic [3:0] vec_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       fail_q;
  logic [4:0] err_q;
  logic [3:0] ff_q;

  logic       exp_w;
  logic       mismatch;
  logic       is_last;
  logic [3:0] vec_d;

  gate_golden_model u_golden (
    .vec_i (vec_q),
    .exp_o (exp_w)
  );

  // Case equality so an X/Z on Y is scored as a mismatch, not skipped.
  assign mismatch = (Y === exp_w) ? 1'b0 : 1'b1;
  assign is_last  = (vec_q == last_vec(mode_q));
  assign vec_d    = vec_q + 4'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_M0;
      vec_q   <= 4'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= 5'd0;
      ff_q    <= 4'd0;
    end else begin
      done_q <= 1'b0;
      if (state_q != ST_IDLE && ABORT) begin
        // Partial results are kept; only the sequencing is dropped.
        state_q <= ST_IDLE;
        vec_q   <= 4'd0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (START && !ABORT) begin
              mode_q  <= MODE_SEL;
              vec_q   <= first_vec(MODE_SEL);
              cnt_q   <= SETTLE_LD;
              err_q   <= 5'd0;
              fail_q  <= 1'b0;
              ff_q    <= 4'd0;
              busy_q  <= 1'b1;
              state_q <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (cnt_q <= 4'd1) begin
              state_q <= ST_SAMPLE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          ST_SAMPLE: begin
            if (mismatch) begin
              err_q <= err_q + 5'd1;
              if (!fail_q) begin
                fail_q <= 1'b1;
                ff_q   <= vec_q;
              end
            end
            if (is_last) begin
              // BUSY drops as DONE rises; stimulus parks at 0000.
              vec_q   <= 4'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              vec_q   <= vec_d;
              cnt_q   <= SETTLE_LD;
              state_q <= ST_SETTLE;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign {M, A, B, C} = vec_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign FAIL         = fail_q;
  assign ERR_CNT      = err_q;
  assign FIRST_FAIL   = ff_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: table of full sweeps plus
// hand-written abort, START-while-busy, START+ABORT and mid-sweep reset cases.
// Y is driven by a bench-side gate model or held stuck at 0/1.
module tb_gate_sweep_ctrl;

  localparam int SC  = 2;
  localparam int VPC = SC + 1;  // cycles per vector

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [1:0] MODE_SEL = 2'b00;
  logic       Y;
  logic       M, A, B, C, BUSY, DONE, FAIL;
  logic [4:0] ERR_CNT;
  logic [3:0] FIRST_FAIL;

  gate_sweep_ctrl #(.SETTLE_CYC(SC)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .MODE_SEL(MODE_SEL), .Y(Y), .M(M), .A(A), .B(B), .C(C),
    .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .ERR_CNT(ERR_CNT),
    .FIRST_FAIL(FIRST_FAIL)
  );

  always #5 CLK = ~CLK;

  // Gate unit truth tables indexed by {A,B,C}.
  logic [7:0] nand_tbl   = 8'b0111_1111;
  logic [7:0] invmaj_tbl = 8'b0001_0111;
  int         y_kind = 0;  // 0 = correct gate, 1 = stuck at 1, 2 = stuck at 0

  always_comb begin
    Y = 1'b0;
    case (y_kind)
      1:       Y = 1'b1;
      2:       Y = 1'b0;
      default: Y = M ? invmaj_tbl[{A, B, C}] : nand_tbl[{A, B, C}];
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_sweep(input logic [1:0] mode);
    @(negedge CLK);
    MODE_SEL = mode;
    START    = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Runs a sweep from acceptance (edge 0) to the DONE cycle and checks
  // vector order, DONE timing and final results. inject_n >= 0 pulses a
  // START with a different mode at that edge offset, which must be ignored.
  task automatic run_sweep(input logic [1:0] mode, input int nvec, input logic [3:0] first,
                           input int exp_done, input logic [4:0] e_err, input logic e_fail,
                           input logic [3:0] e_ff, input int inject_n);
    int got;
    logic [3:0] ev;
    got = -1;
    start_sweep(mode);
    check("busy_after_accept", 32'(BUSY), 32'd1);
    for (int n = 0; n < 80 && got < 0; n++) begin
      if (n > 0) begin
        @(posedge CLK);
        #1;
        START = 1'b0;
      end
      if (n == inject_n) begin
        MODE_SEL = 2'b01;
        START    = 1'b1;
      end
      if ((n % VPC) == 0 && (n / VPC) < nvec) begin
        ev = first + 4'(n / VPC);
        check("vector", 32'({M, A, B, C}), 32'(ev));
      end
      if (DONE) got = n;
    end
    check("done_edge", 32'(got), 32'(exp_done));
    check("busy_in_done", 32'(BUSY), 32'd0);
    check("err_cnt", 32'(ERR_CNT), 32'(e_err));
    check("fail", 32'(FAIL), 32'(e_fail));
    check("first_fail", 32'(FIRST_FAIL), 32'(e_ff));
    check("vec_in_done", 32'({M, A, B, C}), 32'd0);
    @(posedge CLK);
    #1;
    check("done_single_cycle", 32'(DONE), 32'd0);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK);
      #1;
      if (DONE || BUSY) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         ykind;
    int         nvec;
    logic [3:0] first;
    int         done_n;
    logic [4:0] err;
    logic       fail;
    logic [3:0] ff;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // mode, y, nvec, first, DONE edge, err, fail, first_fail
    tbl[0] = '{2'b10, 0, 16, 4'b0000, 48, 5'd0,  1'b0, 4'b0000};
    tbl[1] = '{2'b00, 1,  8, 4'b0000, 24, 5'd1,  1'b1, 4'b0111};
    tbl[2] = '{2'b01, 2,  8, 4'b1000, 24, 5'd4,  1'b1, 4'b1000};
    tbl[3] = '{2'b11, 0, 16, 4'b0000, 48, 5'd0,  1'b0, 4'b0000};
    tbl[4] = '{2'b10, 1, 16, 4'b0000, 48, 5'd5,  1'b1, 4'b0111};
    tbl[5] = '{2'b10, 2, 16, 4'b0000, 48, 5'd11, 1'b1, 4'b0000};

    #12;
    check("reset_outputs", 32'({M, A, B, C, BUSY, DONE, FAIL, ERR_CNT, FIRST_FAIL}), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (tbl[i]) begin
      y_kind = tbl[i].ykind;
      run_sweep(tbl[i].mode, tbl[i].nvec, tbl[i].first, tbl[i].done_n,
                tbl[i].err, tbl[i].fail, tbl[i].ff, -1);
    end

    // Abort after the 3rd SAMPLE (edge 9) with Y stuck at 0: partial results kept.
    y_kind = 2;
    start_sweep(2'b10);
    for (int n = 1; n <= 9; n++) begin
      @(posedge CLK);
      #1;
    end
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_err_kept", 32'(ERR_CNT), 32'd3);
    check("abort_fail_kept", 32'(FAIL), 32'd1);
    check("abort_ff_kept", 32'(FIRST_FAIL), 32'b0000);
    expect_quiet("abort_no_done", 50);

    // Re-START clears results; a correct gate then gives a clean sweep.
    y_kind = 0;
    start_sweep(2'b00);
    check("restart_err_clear", 32'(ERR_CNT), 32'd0);
    check("restart_fail_clear", 32'(FAIL), 32'd0);
    @(posedge CLK);  // let the sweep just started finish before the next one
    for (int n = 0; n < 30 && !DONE; n++) begin
      @(posedge CLK);
      #1;
    end
    check("restart_done", 32'(DONE), 32'd1);
    @(posedge CLK);
    #1;

    // START while BUSY with another mode: ignored, sweep unchanged.
    run_sweep(2'b00, 8, 4'b0000, 24, 5'd0, 1'b0, 4'b0000, 5);
    expect_quiet("busy_start_not_queued", 30);

    // START together with ABORT in IDLE: ignored.
    @(negedge CLK);
    START = 1'b1;
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    ABORT = 1'b0;
    check("start_abort_busy", 32'(BUSY), 32'd0);
    check("start_abort_vec", 32'({M, A, B, C}), 32'd0);
    expect_quiet("start_abort_quiet", 10);

    // Reset mid-SETTLE of vector 0101 (mode 10, Y stuck at 0).
    y_kind = 2;
    start_sweep(2'b10);
    for (int n = 1; n <= 16; n++) begin
      @(posedge CLK);
      #1;
    end
    check("pre_reset_vec", 32'({M, A, B, C}), 32'b0101);
    check("pre_reset_fail", 32'(FAIL), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset_outputs", 32'({M, A, B, C, BUSY, DONE, FAIL, ERR_CNT, FIRST_FAIL}), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    expect_quiet("reset_no_done", 60);

    y_kind = 0;
    run_sweep(2'b01, 8, 4'b1000, 24, 5'd0, 1'b0, 4'b0000, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
